// File: rtl/ext_bus_master.sv
// ext_bus_master: turns a byte-serial host command stream into block-RAM
// word writes and timed word reads, and streams read data plus a status
// byte (0x06 done, 0x15 rejected) back to the host.
//
// Handshakes: a byte moves on cmd_* or rsp_* when valid && ready at a
// rising clock edge; rsp_valid stays high with rsp_data stable until taken.
module ext_bus_master #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int WORD_WIDTH    = 32,
    parameter int READ_LATENCY  = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmd_valid,
    input  logic [7:0]               cmd_data,
    output logic                     cmd_ready,
    output logic                     rsp_valid,
    output logic [7:0]               rsp_data,
    input  logic                     rsp_ready,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic                     mem_write,
    output logic [WORD_WIDTH-1:0]    mem_write_data,
    input  logic [WORD_WIDTH-1:0]    mem_read_data,
    output logic                     busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_HI, S_ADDR_LO, S_WDATA, S_WR,
        S_RD_ISSUE, S_RD_WAIT, S_RD_CAP, S_RSP, S_ACK, S_ERR
    } state_t;

    // Last RD_WAIT count before capture; RD_WAIT is skipped entirely at latency 1.
    localparam logic [1:0] WAIT_LAST = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

    state_t                  state, next_state;
    logic [1:0]              reset_sync;
    logic                    rst_int;
    logic                    is_write;
    logic [3:0]              words_left;
    logic [1:0]              byte_cnt;
    logic [1:0]              wait_cnt;
    logic [7:0]              addr_hi;
    logic [15:0]             addr_full;
    logic [WORD_WIDTH-1:0]   rd_shift;
    logic                    cmd_hs;
    logic                    rsp_hs;

    assign rst_int   = reset_sync[1];
    assign addr_full = {addr_hi, cmd_data};
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;

    // Reset asserts at once and is released in step with the clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) reset_sync <= 2'b11;
        else       reset_sync <= {reset_sync[0], 1'b0};
    end

    // State register.
    always_ff @(posedge clock or posedge rst_int) begin
        if (rst_int) state <= S_IDLE;
        else         state <= next_state;
    end

    // Next-state decode; response states hold until the sink takes the byte.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (cmd_hs) next_state = (cmd_data[6:4] != 3'b000) ? S_ERR : S_ADDR_HI;
            S_ADDR_HI:  if (cmd_hs) next_state = S_ADDR_LO;
            S_ADDR_LO:  if (cmd_hs) next_state = is_write ? S_WDATA : S_RD_ISSUE;
            S_WDATA:    if (cmd_hs && byte_cnt == 2'd3) next_state = S_WR;
            S_WR:       next_state = (words_left == 4'd0) ? S_ACK : S_WDATA;
            S_RD_ISSUE: next_state = (READ_LATENCY > 1) ? S_RD_WAIT : S_RD_CAP;
            S_RD_WAIT:  if (wait_cnt == WAIT_LAST) next_state = S_RD_CAP;
            S_RD_CAP:   next_state = S_RSP;
            S_RSP:      if (rsp_hs && byte_cnt == 2'd3)
                            next_state = (words_left == 4'd0) ? S_ACK : S_RD_ISSUE;
            S_ACK:      if (rsp_ready) next_state = S_IDLE;
            S_ERR:      if (rsp_ready) next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Handshake and strobe outputs decoded from the current state.
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = 8'h00;
        mem_write = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE, S_ADDR_HI, S_ADDR_LO, S_WDATA: cmd_ready = !rst_int;
            S_WR:  mem_write = 1'b1;
            S_RSP: begin
                rsp_valid = 1'b1;
                rsp_data  = rd_shift[WORD_WIDTH-1 -: 8];
            end
            S_ACK: begin
                rsp_valid = 1'b1;
                rsp_data  = 8'h06;
            end
            S_ERR: begin
                rsp_valid = 1'b1;
                rsp_data  = 8'h15;
            end
            default: ;
        endcase
    end

    // Datapath: command fields, address, write assembly and read shifting.
    always_ff @(posedge clock or posedge rst_int) begin
        if (rst_int) begin
            is_write       <= 1'b0;
            words_left     <= 4'd0;
            byte_cnt       <= 2'd0;
            wait_cnt       <= 2'd0;
            addr_hi        <= 8'h00;
            mem_address    <= '0;
            mem_write_data <= '0;
            rd_shift       <= '0;
        end else begin
            case (state)
                S_IDLE: if (cmd_hs) begin
                    is_write   <= cmd_data[7];
                    words_left <= cmd_data[3:0];
                    byte_cnt   <= 2'd0;
                end
                S_ADDR_HI: if (cmd_hs) addr_hi <= cmd_data;
                S_ADDR_LO: if (cmd_hs) begin
                    mem_address <= addr_full[ADDRESS_WIDTH-1:0];
                    byte_cnt    <= 2'd0;
                end
                S_WDATA: if (cmd_hs) begin
                    mem_write_data <= {mem_write_data[WORD_WIDTH-9:0], cmd_data};
                    byte_cnt       <= byte_cnt + 2'd1;
                end
                S_WR: begin
                    mem_address <= mem_address + 1'b1;
                    words_left  <= words_left - 4'd1;
                    byte_cnt    <= 2'd0;
                end
                S_RD_ISSUE: wait_cnt <= 2'd0;
                S_RD_WAIT:  wait_cnt <= wait_cnt + 2'd1;
                S_RD_CAP: begin
                    rd_shift <= mem_read_data;
                    byte_cnt <= 2'd0;
                end
                S_RSP: if (rsp_hs) begin
                    rd_shift <= {rd_shift[WORD_WIDTH-9:0], 8'h00};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        mem_address <= mem_address + 1'b1;
                        words_left  <= words_left - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_bus_master.sv
// Bench for ext_bus_master: two instances (read latency 1 and 3) share one
// RAM model; only the selected instance sees traffic. A reference model
// derives expected RAM writes and response bytes from each packet.
module tb_ext_bus_master;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cur = 1'b0;
    logic        bp_mode = 1'b0;
    logic        cmd_valid_v = 1'b0;
    logic [7:0]  cmd_data_v = 8'h00;
    logic        rsp_ready_v = 1'b1;

    logic        cmd_valid [2];
    logic [7:0]  cmd_data [2];
    logic        cmd_ready [2];
    logic        rsp_valid [2];
    logic [7:0]  rsp_data [2];
    logic        rsp_ready [2];
    logic [15:0] mem_address [2];
    logic        mem_write [2];
    logic [31:0] mem_write_data [2];
    logic [31:0] mem_read_data [2];
    logic        busy [2];

    logic        c_cmd_ready, c_rsp_valid, c_mem_write, c_busy, c_rsp_ready;
    logic [7:0]  c_rsp_data;
    logic [15:0] c_mem_address;
    logic [31:0] c_mem_write_data;

    int checks = 0;
    int errors = 0;

    logic [7:0]  pkt [$];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    logic [47:0] exp_wr_q [$];
    logic [47:0] got_wr_q [$];
    logic [31:0] ref_mem [logic [15:0]];
    logic [31:0] ram [logic [15:0]];
    logic [31:0] pipe0;
    logic [31:0] pipe1 [3];

    // Clock.
    always #5 clock = ~clock;

    assign cmd_valid[0] = cmd_valid_v && (cur == 1'b0);
    assign cmd_valid[1] = cmd_valid_v && (cur == 1'b1);
    assign cmd_data[0]  = cmd_data_v;
    assign cmd_data[1]  = cmd_data_v;
    assign rsp_ready[0] = rsp_ready_v && (cur == 1'b0);
    assign rsp_ready[1] = rsp_ready_v && (cur == 1'b1);
    assign mem_read_data[0] = pipe0;
    assign mem_read_data[1] = pipe1[2];

    assign c_cmd_ready      = cmd_ready[cur];
    assign c_rsp_valid      = rsp_valid[cur];
    assign c_rsp_data       = rsp_data[cur];
    assign c_rsp_ready      = rsp_ready[cur];
    assign c_mem_address    = mem_address[cur];
    assign c_mem_write      = mem_write[cur];
    assign c_mem_write_data = mem_write_data[cur];
    assign c_busy           = busy[cur];

    ext_bus_master #(.ADDRESS_WIDTH(16), .WORD_WIDTH(32), .READ_LATENCY(1)) dut_l1 (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid[0]), .cmd_data(cmd_data[0]), .cmd_ready(cmd_ready[0]),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_ready(rsp_ready[0]),
        .mem_address(mem_address[0]), .mem_write(mem_write[0]),
        .mem_write_data(mem_write_data[0]), .mem_read_data(mem_read_data[0]),
        .busy(busy[0])
    );

    ext_bus_master #(.ADDRESS_WIDTH(16), .WORD_WIDTH(32), .READ_LATENCY(3)) dut_l3 (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid[1]), .cmd_data(cmd_data[1]), .cmd_ready(cmd_ready[1]),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_ready(rsp_ready[1]),
        .mem_address(mem_address[1]), .mem_write(mem_write[1]),
        .mem_write_data(mem_write_data[1]), .mem_read_data(mem_read_data[1]),
        .busy(busy[1])
    );

    // Background contents of never-written RAM words, distinct per address.
    function automatic logic [31:0] bg(input logic [15:0] a);
        return {a ^ 16'h5A3C, ~a};
    endfunction

    function automatic logic [31:0] ram_rd(input logic [15:0] a);
        return ram.exists(a) ? ram[a] : bg(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : bg(a);
    endfunction

    // RAM read pipelines: data appears READ_LATENCY edges after the address.
    always @(posedge clock) begin
        pipe0    <= ram_rd(mem_address[0]);
        pipe1[0] <= ram_rd(mem_address[1]);
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Random response back-pressure, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            rsp_ready_v = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor on the falling edge: records transfers that complete at the
    // next rising edge, commits RAM writes, and checks stalled responses.
    initial begin
        logic        stall_prev;
        logic [7:0]  stall_data;
        logic [15:0] stall_addr;
        stall_prev = 1'b0;
        stall_data = 8'h00;
        stall_addr = 16'h0000;
        forever begin
            @(negedge clock);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (c_mem_write) begin
                    got_wr_q.push_back({c_mem_address, c_mem_write_data});
                    ram[c_mem_address] = c_mem_write_data;
                end
                if (stall_prev) begin
                    check("stall_valid", c_rsp_valid, 1'b1);
                    check("stall_data", c_rsp_data, stall_data);
                    check("stall_addr", c_mem_address, stall_addr);
                end
                if (c_rsp_valid && c_rsp_ready) got_q.push_back(c_rsp_data);
                stall_prev = c_rsp_valid && !c_rsp_ready;
                stall_data = c_rsp_data;
                stall_addr = c_mem_address;
            end
        end
    end

    // Reference model: expected writes and response bytes for pkt.
    task automatic model_packet();
        logic [7:0]  c;
        logic [15:0] a;
        logic [31:0] d;
        int          n;
        c = pkt[0];
        if (c[6:4] != 3'b000) begin
            exp_q.push_back(8'h15);
            return;
        end
        n = int'(c[3:0]) + 1;
        a = {pkt[1], pkt[2]};
        for (int w = 0; w < n; w++) begin
            if (c[7]) begin
                d = {pkt[3 + 4*w], pkt[4 + 4*w], pkt[5 + 4*w], pkt[6 + 4*w]};
                exp_wr_q.push_back({a, d});
                ref_mem[a] = d;
            end else begin
                d = ref_rd(a);
                for (int b = 3; b >= 0; b--) exp_q.push_back(d[8*b +: 8]);
            end
            a = a + 16'd1;
        end
        exp_q.push_back(8'h06);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic done;
        n = 0;
        done = 1'b0;
        cmd_valid_v = 1'b1;
        cmd_data_v  = b;
        while (!done && n < 500) begin
            @(negedge clock);
            done = c_cmd_ready;
            @(posedge clock);
            #1;
            n++;
        end
        cmd_valid_v = 1'b0;
        check("cmd_accept", done, 1'b1);
    endtask

    task automatic make_cmd(input logic w, input int n, input logic [15:0] a);
        pkt.delete();
        pkt.push_back({w, 3'b000, 4'(n - 1)});
        pkt.push_back(a[15:8]);
        pkt.push_back(a[7:0]);
        if (w) for (int i = 0; i < 4*n; i++) pkt.push_back(8'($urandom));
    endtask

    // Send pkt, wait for the response, then compare everything observed.
    task automatic run_packet();
        int n;
        model_packet();
        foreach (pkt[i]) send_byte(pkt[i]);
        n = 0;
        while (got_q.size() < exp_q.size() && n < 3000) begin
            @(posedge clock);
            n++;
        end
        repeat (4) @(posedge clock);
        #1;
        check("rsp_count", got_q.size(), exp_q.size());
        check("wr_count", got_wr_q.size(), exp_wr_q.size());
        while (exp_q.size() > 0) begin
            logic [7:0] e, g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            check("rsp_byte", g, e);
        end
        while (exp_wr_q.size() > 0) begin
            logic [47:0] e, g;
            e = exp_wr_q.pop_front();
            g = (got_wr_q.size() > 0) ? got_wr_q.pop_front() : 48'hx;
            check("wr_addr_data", g, e);
        end
        check("idle_busy", c_busy, 1'b0);
        check("idle_ready", c_cmd_ready, 1'b1);
        got_q.delete();
        got_wr_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, c_cmd_ready, 1'b0);
        check({tag, "_rsp_valid"}, c_rsp_valid, 1'b0);
        check({tag, "_rsp_data"}, c_rsp_data, 8'h00);
        check({tag, "_mem_address"}, c_mem_address, 16'h0000);
        check({tag, "_mem_write"}, c_mem_write, 1'b0);
        check({tag, "_mem_wdata"}, c_mem_write_data, 32'h0);
        check({tag, "_busy"}, c_busy, 1'b0);
    endtask

    // Directed and randomized sequence.
    initial begin
        #1 reset = 1'b1;
        #2;
        check_reset_outputs("reset");
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;

        // Single write then read back at latency 1.
        pkt.delete();
        pkt.push_back(8'h80); pkt.push_back(8'h00); pkt.push_back(8'h10);
        pkt.push_back(8'hDE); pkt.push_back(8'hAD); pkt.push_back(8'hBE); pkt.push_back(8'hEF);
        run_packet();
        make_cmd(1'b0, 1, 16'h0010);
        run_packet();

        // Burst across the top of the address space.
        make_cmd(1'b1, 3, 16'hFFFE);
        run_packet();
        make_cmd(1'b0, 3, 16'hFFFE);
        run_packet();

        // Random write/read pairs; reads under random back-pressure.
        for (int k = 0; k < 3; k++) begin
            int          n;
            logic [15:0] a;
            n = $urandom_range(1, 16);
            a = 16'($urandom);
            make_cmd(1'b1, n, a);
            run_packet();
            bp_mode = 1'b1;
            make_cmd(1'b0, n, a);
            run_packet();
            bp_mode = 1'b0;
        end

        // Rejected command, then a normal read.
        pkt.delete();
        pkt.push_back(8'h40);
        run_packet();
        make_cmd(1'b0, 1, 16'h0000);
        run_packet();

        // Reset after the third data byte of a write: nothing committed.
        send_byte(8'h80);
        send_byte(8'h00);
        send_byte(8'h20);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("midreset_no_write", got_wr_q.size(), 0);
        check("midreset_no_rsp", got_q.size(), 0);
        got_q.delete();
        got_wr_q.delete();
        make_cmd(1'b0, 1, 16'h0020);
        run_packet();

        // Latency-3 instance.
        cur = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        make_cmd(1'b0, 1, 16'h0010);
        run_packet();
        bp_mode = 1'b1;
        make_cmd(1'b0, 3, 16'hFFFE);
        run_packet();
        bp_mode = 1'b0;
        begin
            int          n;
            logic [15:0] a;
            n = $urandom_range(2, 16);
            a = 16'($urandom);
            make_cmd(1'b1, n, a);
            run_packet();
            bp_mode = 1'b1;
            make_cmd(1'b0, n, a);
            run_packet();
            bp_mode = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
